// File: rtl/rst_seq.sv
// Board reset sequencer: waits for clock-manager lock, holds all resets, then
// releases N_STAGE subsystem resets in order; lock loss or soft button aborts.
module rst_seq #(
    parameter int N_STAGE         = 3,
    parameter int HOLD_CYCLES     = 63,
    parameter int STAGE_GAP       = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_locked,
    input  logic               i_sw_rst,
    output logic [N_STAGE-1:0] o_rst,
    output logic               o_ready,
    output logic [1:0]         o_cause,
    output logic [7:0]         o_count
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int GAP_W  = $clog2(STAGE_GAP) + 1;
    localparam int STG_W  = $clog2(N_STAGE) + 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0]  LAST_STG  = STG_W'(N_STAGE - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_BTN  = 2'd2;

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   locked_s;
    logic                   btn_s;
    logic                   btn_db;
    logic [DEB_W-1:0]       deb_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [STG_W-1:0]       stage;
    logic                   abort;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign locked_s = lock_sync[SYNC_STAGES-1];
    assign btn_s    = btn_sync[SYNC_STAGES-1];
    assign abort    = (state != WAIT_LOCK) && (!locked_s || btn_db);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_sync <= '0;
            btn_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], i_locked};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], i_sw_rst};
        end
    end

    // Filtered level only follows the button after DEBOUNCE_CYCLES steady edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_db  <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s == btn_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            btn_db  <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            stage    <= '0;
            o_rst    <= '1;
            o_ready  <= 1'b0;
            o_cause  <= 2'd0;
            o_count  <= 8'd0;
        end else if (abort) begin
            state   <= WAIT_LOCK;
            o_rst   <= '1;
            o_ready <= 1'b0;
            o_cause <= locked_s ? CAUSE_BTN : CAUSE_LOCK;
            o_count <= sat_inc(o_count);
        end else begin
            case (state)
                WAIT_LOCK: begin
                    o_rst   <= '1;
                    o_ready <= 1'b0;
                    if (locked_s && !btn_db) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        // Shifting a zero in releases the lowest still-asserted stage.
                        o_rst <= o_rst << 1;
                        if (N_STAGE > 1) begin
                            state   <= RELEASE;
                            stage   <= STG_W'(1);
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state   <= RUN;
                            o_ready <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt == '0) begin
                        o_rst <= o_rst << 1;
                        if (stage == LAST_STG) begin
                            state   <= RUN;
                            o_ready <= 1'b1;
                        end else begin
                            stage   <= stage + STG_W'(1);
                            gap_cnt <= GAP_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                RUN: begin
                    o_rst   <= '0;
                    o_ready <= 1'b1;
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end
endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed scenarios with literal timing pins plus random
// lock/button activity, all checked every cycle against an event-time model.
module tb_rst_seq;
    localparam int NS   = 3;
    localparam int HOLD = 8;
    localparam int GAP  = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 5;

    logic          clock;
    logic          reset;
    logic          i_locked;
    logic          i_sw_rst;
    logic [NS-1:0] o_rst;
    logic          o_ready;
    logic [1:0]    o_cause;
    logic [7:0]    o_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    rst_seq #(
        .N_STAGE(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP),
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock), .reset(reset), .i_locked(i_locked), .i_sw_rst(i_sw_rst),
        .o_rst(o_rst), .o_ready(o_ready), .o_cause(o_cause), .o_count(o_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: sequencer described by "edges since the lock+no-button condition was seen".
    bit m_active = 0;
    int m_t      = 0;
    int m_cause  = 0;
    int m_count  = 0;
    bit m_lk_s   = 0;
    bit m_btn_s  = 0;
    bit m_db     = 0;
    int m_run    = 0;
    bit lq[$];
    bit bq[$];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 0; m_t = 0; m_cause = 0; m_count = 0;
            m_lk_s = 0; m_btn_s = 0; m_db = 0; m_run = 0;
            lq.delete(); bq.delete();
        end else begin
            if (m_active) begin
                if (!m_lk_s || m_db) begin
                    m_active = 0;
                    m_cause  = !m_lk_s ? 1 : 2;
                    m_count  = (m_count < 255) ? m_count + 1 : 255;
                end else if (m_t < 100000) begin
                    m_t++;
                end
            end else if (m_lk_s && !m_db) begin
                m_active = 1;
                m_t      = 0;
            end
            if (m_btn_s != m_db) begin
                m_run++;
                if (m_run == DEB) begin
                    m_db  = m_btn_s;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            lq.push_back(i_locked);
            bq.push_back(i_sw_rst);
            if (lq.size() > SYNC) void'(lq.pop_front());
            if (bq.size() > SYNC) void'(bq.pop_front());
            m_lk_s  = (lq.size() == SYNC) ? lq[0] : 1'b0;
            m_btn_s = (bq.size() == SYNC) ? bq[0] : 1'b0;
        end
    end

    function automatic int exp_rel();
        int r;
        if (!m_active || m_t < HOLD) return 0;
        r = 1 + (m_t - HOLD) / GAP;
        return (r > NS) ? NS : r;
    endfunction

    always @(negedge clock) begin
        int rel;
        int mask;
        if (cyc > 0) begin
            rel  = exp_rel();
            mask = ((1 << NS) - 1) & ~((1 << rel) - 1);
            chk("model_o_rst", int'(o_rst), mask);
            chk("model_o_ready", int'(o_ready), (rel == NS) ? 1 : 0);
            chk("model_o_cause", int'(o_cause), m_cause);
            chk("model_o_count", int'(o_count), m_count);
        end
    end

    task automatic go_after(input int e);
        while (cyc < e) @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n, m, p, r, btn_left;
        reset = 1'b1; i_locked = 1'b1; i_sw_rst = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        c0 = cyc;
        chk("reset_o_rst", int'(o_rst), 7);
        chk("reset_o_ready", int'(o_ready), 0);
        chk("reset_o_count", int'(o_count), 0);

        // Power-up release timing
        go_after(c0 + 10); chk("pu_e10_rst", int'(o_rst), 7);
        go_after(c0 + 11); chk("pu_e11_rst", int'(o_rst), 6);
        go_after(c0 + 14); chk("pu_e14_rst", int'(o_rst), 6);
        go_after(c0 + 15); chk("pu_e15_rst", int'(o_rst), 4);
        go_after(c0 + 18); chk("pu_e18_ready", int'(o_ready), 0);
        go_after(c0 + 19); chk("pu_e19_rst", int'(o_rst), 0);
        chk("pu_e19_ready", int'(o_ready), 1);
        chk("pu_count", int'(o_count), 0);
        chk("pu_cause", int'(o_cause), 0);

        // Lock loss in RUN, then relock
        go_after(c0 + 25);
        i_locked = 1'b0; n = cyc + 1;
        go_after(n + 1); chk("ll_n1_rst", int'(o_rst), 0);
        go_after(n + 2); chk("ll_n2_rst", int'(o_rst), 7);
        chk("ll_ready", int'(o_ready), 0);
        chk("ll_cause", int'(o_cause), 1);
        chk("ll_count", int'(o_count), 1);
        i_locked = 1'b1; m = cyc + 1;
        go_after(m + 9);  chk("rl_m9_rst", int'(o_rst), 7);
        go_after(m + 10); chk("rl_m10_rst", int'(o_rst), 6);
        go_after(m + 14); chk("rl_m14_rst", int'(o_rst), 4);
        go_after(m + 18); chk("rl_m18_ready", int'(o_ready), 1);

        // Short button pulse is filtered out
        go_after(m + 20);
        i_sw_rst = 1'b1;
        repeat (3) @(negedge clock);
        i_sw_rst = 1'b0;
        repeat (12) @(negedge clock);
        chk("pulse_rst", int'(o_rst), 0);
        chk("pulse_count", int'(o_count), 1);

        // Held button
        i_sw_rst = 1'b1; p = cyc + 1;
        go_after(p + 6); chk("btn_p6_rst", int'(o_rst), 0);
        go_after(p + 7); chk("btn_p7_rst", int'(o_rst), 7);
        chk("btn_cause", int'(o_cause), 2);
        chk("btn_count", int'(o_count), 2);
        go_after(p + 9); i_sw_rst = 1'b0;
        go_after(p + 24); chk("btn_p24_rst", int'(o_rst), 7);
        go_after(p + 25); chk("btn_p25_rst", int'(o_rst), 6);
        go_after(p + 33); chk("btn_p33_ready", int'(o_ready), 1);

        // Abort mid-release
        go_after(p + 36);
        i_locked = 1'b0;
        go_after(p + 39); i_locked = 1'b1; m = cyc + 1;
        chk("mr_count_a", int'(o_count), 3);
        go_after(m + 10); chk("mr_m10_rst", int'(o_rst), 6);
        i_locked = 1'b0;
        go_after(m + 12); chk("mr_m12_rst", int'(o_rst), 6);
        go_after(m + 13); chk("mr_m13_rst", int'(o_rst), 7);
        chk("mr_count_b", int'(o_count), 4);
        chk("mr_cause", int'(o_cause), 1);
        i_locked = 1'b1; r = cyc + 1;
        go_after(r + 18); chk("mr_ready", int'(o_ready), 1);

        // Async reset during RUN
        go_after(r + 22);
        #2 reset = 1'b1;
        #1;
        chk("ar_rst", int'(o_rst), 7);
        chk("ar_ready", int'(o_ready), 0);
        chk("ar_count", int'(o_count), 0);
        chk("ar_cause", int'(o_cause), 0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;

        // Random lock/button activity
        btn_left = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 59) == 0) i_locked = ~i_locked;
            if (btn_left > 0) begin
                btn_left--;
                if (btn_left == 0) i_sw_rst = 1'b0;
            end else if ($urandom_range(0, 79) == 0) begin
                i_sw_rst = 1'b1;
                btn_left = $urandom_range(1, 12);
            end
        end

        // Saturation of the event counter
        i_sw_rst = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 260; k++) begin
            i_locked = 1'b1;
            repeat (4) @(negedge clock);
            i_locked = 1'b0;
            repeat (3) @(negedge clock);
        end
        repeat (2) @(negedge clock);
        chk("sat_count", int'(o_count), 255);
        chk("sat_cause", int'(o_cause), 1);
        chk("sat_rst", int'(o_rst), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
